// File: rtl/mig_calib_supervisor.sv
// mig_calib_supervisor: sequences DDR bring-up behind the MIG reset timer.
// It enables the timer, waits for the MIG reset to be released, and then
// watches the calibration flag with a timeout. On timeout or lost calibration
// it restarts the timer after a back-off, up to MAX_RETRIES times. After that
// the failure is sticky until reset.
// Optional feature macro: MIG_CALIB_SYNC_EN adds a 2-flop synchronizer on the
// calibration flag, for use when the flag comes from the MIG ui_clk domain.
module mig_calib_supervisor #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TIMEOUT_WIDTH  = 22,
  parameter int SETTLE_CYCLES  = 256,
  parameter int BACKOFF_CYCLES = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_WIDTH    = 2
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Mig_Reset_Released,
  input  logic                   i_Init_Calib_Complete,
  output logic                   o_Timer_Enable,
  output logic                   o_Ready,
  output logic                   o_Fail,
  output logic [RETRY_WIDTH-1:0] o_Retry_Count
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] BACKOFF_LAST = TIMEOUT_WIDTH'(BACKOFF_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]      SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_WIDTH-1:0]   RETRY_MAX    = RETRY_WIDTH'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENABLE  = 3'd1,
    CALIB   = 3'd2,
    SETTLE  = 3'd3,
    READY   = 3'd4,
    BACKOFF = 3'd5,
    FAIL    = 3'd6
  } state_t;

  state_t                   state, state_next;
  logic [TIMEOUT_WIDTH-1:0] count, count_next;
  logic [SETTLE_W-1:0]      settle, settle_next;
  logic [RETRY_WIDTH-1:0]   retry_next;
  logic                     enable_next, ready_next, fail_next;
  logic                     calib_s;

`ifdef MIG_CALIB_SYNC_EN
  logic [1:0] calib_sync;

  // Two-flop synchronizer for the calibration flag from the ui_clk domain.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) calib_sync <= 2'b00;
    else         calib_sync <= {calib_sync[0], i_Init_Calib_Complete};
  end

  assign calib_s = calib_sync[1];
`else
  assign calib_s = i_Init_Calib_Complete;
`endif

  // State, counters and registered outputs; reset drops the timer enable at once.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= IDLE;
      count          <= '0;
      settle         <= '0;
      o_Retry_Count  <= '0;
      o_Timer_Enable <= 1'b0;
      o_Ready        <= 1'b0;
      o_Fail         <= 1'b0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      settle         <= settle_next;
      o_Retry_Count  <= retry_next;
      o_Timer_Enable <= enable_next;
      o_Ready        <= ready_next;
      o_Fail         <= fail_next;
    end
  end

  // Next-state, counter updates, and output decode from the next state.
  always_comb begin
    state_next  = state;
    count_next  = count;
    settle_next = settle;
    retry_next  = o_Retry_Count;

    unique case (state)
      IDLE: state_next = ENABLE;

      ENABLE: begin
        if (i_Mig_Reset_Released) begin
          count_next = '0;
          state_next = CALIB;
        end
      end

      CALIB: begin
        if (calib_s) begin
          settle_next = '0;
          state_next  = SETTLE;
        end else if (count == TIMEOUT_LAST) begin
          if (o_Retry_Count < RETRY_MAX) begin
            retry_next = o_Retry_Count + RETRY_WIDTH'(1);
            count_next = '0;
            state_next = BACKOFF;
          end else begin
            state_next = FAIL;
          end
        end else begin
          count_next = count + TIMEOUT_WIDTH'(1);
        end
      end

      SETTLE: begin
        // The timeout keeps running while settling but saturates, so a
        // glitch after the budget is spent times out on return to CALIB
        // instead of wrapping the counter.
        if (count != TIMEOUT_LAST) count_next = count + TIMEOUT_WIDTH'(1);
        if (!calib_s)                    state_next  = CALIB;
        else if (settle == SETTLE_LAST)  state_next  = READY;
        else                             settle_next = settle + SETTLE_W'(1);
      end

      READY: begin
        if (!calib_s) begin
          if (o_Retry_Count < RETRY_MAX) begin
            retry_next = o_Retry_Count + RETRY_WIDTH'(1);
            count_next = '0;
            state_next = BACKOFF;
          end else begin
            state_next = FAIL;
          end
        end
      end

      BACKOFF: begin
        if (count == BACKOFF_LAST) state_next = ENABLE;
        else                       count_next = count + TIMEOUT_WIDTH'(1);
      end

      FAIL: state_next = FAIL;

      default: state_next = IDLE;
    endcase

    enable_next = (state_next == ENABLE) || (state_next == CALIB) ||
                  (state_next == SETTLE) || (state_next == READY);
    ready_next  = (state_next == READY);
    fail_next   = (state_next == FAIL);
  end

endmodule
